uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx_top instance between NUM_REQ byte producers. It captures the winning requester's byte and drives the UART's P_DATA/DATA_VALID. It tracks the UART BUSY to sequence one frame at a time, and reports completion or start-timeout per transfer. It sits directly in front of uart_tx_top; parity settings pass through unchanged.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester index; 2**ID_W >= NUM_REQ
DATA_WIDTH, 8, byte width; matches uart_tx_top DATA_WIDTH
START_TIMEOUT, 4, cycles to wait for TX_BUSY rise after launch (>=2)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
REQ  in  NUM_REQ  per-requester transmit request, level
REQ_DATA  in  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
ACK  out  NUM_REQ  one-cycle pulse: requester's byte captured
TX_BUSY  in  1  BUSY from uart_tx_top
TX_P_DATA  out  DATA_WIDTH  to uart_tx_top P_DATA
TX_DATA_VALID  out  1  to uart_tx_top DATA_VALID
GNT_ID  out  ID_W  index of current/last granted requester
DONE  out  1  one-cycle pulse: granted frame finished
ERR  out  1  one-cycle pulse: TX_BUSY never rose (start timeout)

Behaviour:
- Reset (async, RST=1): state IDLE; ACK=0, TX_P_DATA=0, TX_DATA_VALID=0, GNT_ID=0, DONE=0, ERR=0; timeout counter 0; round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first. Reset mid-transfer aborts silently with no DONE or ERR.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If TX_BUSY=0 and |REQ: select the first asserted REQ searching last+1, last+2, ... with wrap at NUM_REQ.
  - On that edge: TX_P_DATA<=winner byte, GNT_ID<=winner, last<=winner, ACK[winner]<=1, TX_DATA_VALID<=1; go LAUNCH.
  - If TX_BUSY=1 (external/previous frame), no grant.
- LAUNCH (exactly 1 cycle): TX_DATA_VALID=1 and ACK pulse are visible this cycle. Next edge clears both; go WAIT_BUSY; counter<=0.
- Latency: REQ first sampled high in IDLE at edge k gives TX_DATA_VALID high during cycle k+1 (1 cycle).
- WAIT_BUSY:
  - TX_BUSY=1: go WAIT_DONE.
  - Otherwise counter++.
  - When counter==START_TIMEOUT-1 with TX_BUSY still 0: ERR pulse 1 cycle, go IDLE. Pointer remains advanced, so the requester loses its turn; its byte is not retried.
- WAIT_DONE: on TX_BUSY=0, DONE pulse 1 cycle, go IDLE.
- TX_P_DATA and GNT_ID hold from grant until the next grant; REQ_DATA changes after capture have no effect.
- REQ sampling: REQ is ignored in LAUNCH/WAIT_*. A requester keeping REQ high after ACK is re-arbitrated fairly; one ACK means one byte.
- Back-to-back: the earliest next TX_DATA_VALID is 2 cycles after TX_BUSY falls (DONE cycle in IDLE, grant edge, LAUNCH).
- Simultaneous DONE and new REQ: the request is handled in IDLE the following cycle.
- Single requester: served every frame; pointer wrap does not starve it.
- REQ deasserted before grant: no ACK, no transfer.
- Never more than one ACK bit set; ACK never asserted outside LAUNCH.

Test Plan:
- Single request: REQ=0001, REQ_DATA[7:0]=0xA5, TX_BUSY driven by a real uart_tx_top (parity off) -> ACK=0001 one cycle, TX_DATA_VALID one cycle, TX_P_DATA=0xA5, serial line carries 0xA5 LSB-first, DONE after stop bit, GNT_ID=0.
- Simultaneous requests REQ=1111 held with bytes 0x10,0x11,0x12,0x13 -> frames in order 0x10,0x11,0x12,0x13,0x10; ACK sequence 0001,0010,0100,1000,0001; exactly one DONE per frame.
- Fairness after partial: grant 2, then REQ=0101 -> next grant 0 (wrap from 3), then 2.
- Start timeout: TX_BUSY tied 0, REQ=0010 -> TX_DATA_VALID pulse, ERR high exactly START_TIMEOUT cycles after LAUNCH, no DONE, state IDLE; next REQ=0011 grants 0 first.
- External busy: TX_BUSY=1 in IDLE with REQ=0001 -> no ACK/VALID until TX_BUSY=0, then grant next cycle.
- Reset mid-WAIT_DONE: assert RST during a frame -> all outputs 0 immediately (async), no DONE/ERR; after release REQ=1000 then REQ=1001 -> requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx_top between NUM_REQ byte producers,
// launching one frame at a time and reporting completion or start timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ID_W          = 2,
   parameter int DATA_WIDTH    = 8,
   parameter int START_TIMEOUT = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]            ACK,
   input  logic                          TX_BUSY,
   output logic [DATA_WIDTH-1:0]         TX_P_DATA,
   output logic                          TX_DATA_VALID,
   output logic [ID_W-1:0]               GNT_ID,
   output logic                          DONE,
   output logic                          ERR
);

   localparam int CNT_W = $clog2(START_TIMEOUT);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LAUNCH    = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]       state;
   logic [ID_W-1:0]  last;
   logic [CNT_W-1:0] cnt;
   logic [ID_W-1:0]  winner;
   logic             found;

   // Search starts just after the last winner so every requester gets a turn.
   // NOTE: every variable assigned here gets a default first, so no latch is inferred.
   always_comb begin
      winner = last;
      found  = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && REQ[(int'(last) + k) % NUM_REQ]) begin
            found  = 1'b1;
            winner = ID_W'((int'(last) + k) % NUM_REQ);
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= S_IDLE;
         last          <= ID_W'(NUM_REQ - 1);
         cnt           <= '0;
         ACK           <= '0;
         TX_P_DATA     <= '0;
         TX_DATA_VALID <= 1'b0;
         GNT_ID        <= '0;
         DONE          <= 1'b0;
         ERR           <= 1'b0;
      end else begin
         ACK  <= '0;
         DONE <= 1'b0;
         ERR  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!TX_BUSY && found) begin
                  TX_P_DATA     <= REQ_DATA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  GNT_ID        <= winner;
                  last          <= winner;
                  ACK           <= NUM_REQ'(1) << winner;
                  TX_DATA_VALID <= 1'b1;
                  state         <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               TX_DATA_VALID <= 1'b0;
               cnt           <= '0;
               state         <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (TX_BUSY) begin
                  state <= S_WAIT_DONE;
               end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                  // The pointer already moved past this requester; its byte is dropped.
                  ERR   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!TX_BUSY) begin
                  DONE  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a behavioural UART busy model plus a
// round-robin reference (next asserted index after the last winner, modulo NUM_REQ).
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int DW      = 8;
   localparam int TO      = 4;
   localparam int FRAME   = 10;   // start + 8 data + stop at one clock per bit

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    ack;
   logic                  tx_busy;
   logic [DW-1:0]         tx_p_data;
   logic                  tx_data_valid;
   logic [ID_W-1:0]       gnt_id;
   logic                  done;
   logic                  err;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_WIDTH(DW), .START_TIMEOUT(TO)
   ) dut (
      .CLK(clk), .RST(rst), .REQ(req), .REQ_DATA(req_data), .ACK(ack),
      .TX_BUSY(tx_busy), .TX_P_DATA(tx_p_data), .TX_DATA_VALID(tx_data_valid),
      .GNT_ID(gnt_id), .DONE(done), .ERR(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART stand-in: busy_mode 0 = frame model, 1 = busy tied low, 2 = busy held high
   int   busy_mode = 0;
   logic uart_busy = 1'b0;
   int   uart_cnt  = 0;
   int   fall_cyc  = 0;
   assign tx_busy = (busy_mode == 0) ? uart_busy : (busy_mode == 2);

   always @(negedge clk) begin
      if (rst) begin
         uart_busy = 1'b0;
         uart_cnt  = 0;
      end else if (uart_busy) begin
         uart_cnt--;
         if (uart_cnt == 0) begin
            uart_busy = 1'b0;
            fall_cyc  = cyc;
         end
      end else if (tx_data_valid && busy_mode == 0) begin
         uart_busy = 1'b1;
         uart_cnt  = FRAME;
      end
   end

   // Grant monitor: records every ACK with its byte and cycle, counts DONE/ERR.
   int            g_id_q[$];
   logic [DW-1:0] g_dat_q[$];
   int            g_cyc_q[$];
   int            done_cnt = 0;
   int            err_cnt  = 0;
   int            err_cyc  = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (ack != '0) begin
            n_cmp++;
            if (!$onehot(ack) || !tx_data_valid || ack !== (4'b0001 << gnt_id)) begin
               n_bad++;
               $display("FAIL ack_shape: ack=%b valid=%b gnt_id=%0d, need one-hot ack matching gnt_id with valid", ack, tx_data_valid, gnt_id);
            end
            g_id_q.push_back(int'(gnt_id));
            g_dat_q.push_back(tx_p_data);
            g_cyc_q.push_back(cyc);
         end else if (tx_data_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL valid_without_ack: valid=1 ack=%b, need an ACK with every launch", ack);
         end
         if (done) done_cnt++;
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
         end
      end
   end

   int model_last;

   function automatic int pick(input int last, input logic [NUM_REQ-1:0] r);
      for (int k = 1; k <= NUM_REQ; k++)
         if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      return -1;
   endfunction

   // Waits for the next recorded grant and compares it against the model's choice.
   task automatic expect_grant(input string name, input int exp_id, input logic [DW-1:0] exp_dat,
                               output int gc);
      int waited = 0;
      gc = -1;
      while (g_id_q.size() == 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (g_id_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: no grant within 200 cycles, need grant %0d", name, exp_id);
      end else begin
         int            id;
         logic [DW-1:0] dat;
         id  = g_id_q.pop_front();
         dat = g_dat_q.pop_front();
         gc  = g_cyc_q.pop_front();
         if (id !== exp_id || dat !== exp_dat) begin
            n_bad++;
            $display("FAIL %s: got id=%0d data=%h, need id=%0d data=%h", name, id, dat, exp_id, exp_dat);
         end
      end
      model_last = exp_id;
   endtask

   task automatic wait_done(input string name, input int target);
      int waited = 0;
      while (done_cnt < target && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (done_cnt < target) begin
         n_bad++;
         $display("FAIL %s: done count %0d after 200 cycles, need %0d", name, done_cnt, target);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; req_data = '0; busy_mode = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({ack, tx_p_data, tx_data_valid, gnt_id, done, err} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: ack=%b data=%h valid=%b id=%0d done=%b err=%b, need all zero",
                  ack, tx_p_data, tx_data_valid, gnt_id, done, err);
      end
      rst = 1'b0;
      model_last = NUM_REQ - 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int c0, gc, d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      req_data = $urandom; req_data[7:0] = 8'hA5; req = 4'b0001;
      c0 = cyc;
      expect_grant("single_grant", pick(model_last, req), 8'hA5, gc);
      n_cmp++;
      if (gc !== c0 + 1) begin
         n_bad++;
         $display("FAIL single_latency: valid at cycle %0d, need %0d", gc, c0 + 1);
      end
      req = '0; req_data = $urandom;
      wait_done("single_done", d0 + 1);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tx_p_data !== 8'hA5 || gnt_id !== 2'd0 || done_cnt !== d0 + 1 || err_cnt !== e0) begin
         n_bad++;
         $display("FAIL single_hold: data=%h id=%0d dones=%0d errs=%0d, need A5 0 %0d %0d",
                  tx_p_data, gnt_id, done_cnt - d0, err_cnt - e0, 1, 0);
      end
   endtask

   task automatic test_round_robin();
      int d0, gc, exp;
      d0 = done_cnt;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         exp = pick(model_last, req);
         expect_grant($sformatf("rr_grant%0d", i), exp, req_data[exp*DW +: DW], gc);
         if (i > 0) begin
            n_cmp++;
            if (gc !== fall_cyc + 2) begin
               n_bad++;
               $display("FAIL rr_back_to_back%0d: valid at cycle %0d, need %0d", i, gc, fall_cyc + 2);
            end
         end
      end
      req = '0;
      wait_done("rr_done", d0 + 5);
      repeat (4) @(negedge clk);
      n_cmp++;
      if (done_cnt !== d0 + 5) begin
         n_bad++;
         $display("FAIL rr_done_count: got %0d, need 5", done_cnt - d0);
      end
   endtask

   task automatic test_fairness();
      int d0, gc, exp;
      d0 = done_cnt;
      req_data = $urandom;
      req = 4'b0100;
      exp = pick(model_last, req);
      expect_grant("fair_first", exp, req_data[exp*DW +: DW], gc);
      req = '0;
      wait_done("fair_done1", d0 + 1);
      req = 4'b0101;
      for (int i = 0; i < 2; i++) begin
         exp = pick(model_last, req);
         expect_grant($sformatf("fair_next%0d", i), exp, req_data[exp*DW +: DW], gc);
      end
      req = '0;
      wait_done("fair_done2", d0 + 3);
   endtask

   task automatic test_timeout();
      int d0, e0, gc, exp, waited;
      d0 = done_cnt; e0 = err_cnt;
      busy_mode = 1;
      req_data = $urandom;
      req = 4'b0010;
      exp = pick(model_last, req);
      expect_grant("to_grant", exp, req_data[exp*DW +: DW], gc);
      req = '0;
      waited = 0;
      while (err_cnt == e0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      repeat (3) @(negedge clk);
      // LAUNCH at gc, then TO cycles of waiting, ERR visible on the cycle after.
      n_cmp++;
      if (err_cnt !== e0 + 1 || err_cyc !== gc + TO + 1 || done_cnt !== d0) begin
         n_bad++;
         $display("FAIL to_err: errs=%0d at cycle %0d dones=%0d, need 1 at %0d and 0 dones",
                  err_cnt - e0, err_cyc, done_cnt - d0, gc + TO + 1);
      end
      busy_mode = 0;
      req_data = $urandom;
      req = 4'b0011;
      exp = pick(model_last, req);
      expect_grant("to_after", exp, req_data[exp*DW +: DW], gc);
      req = '0;
      wait_done("to_after_done", d0 + 1);
   endtask

   task automatic test_ext_busy();
      int d0, c0, gc, exp;
      d0 = done_cnt;
      busy_mode = 2;
      req_data = $urandom;
      req = 4'b0001;
      repeat (6) @(negedge clk);
      n_cmp++;
      if (g_id_q.size() !== 0) begin
         n_bad++;
         $display("FAIL ext_busy_block: %0d grants while busy, need 0", g_id_q.size());
      end
      req = '0;
      busy_mode = 0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (g_id_q.size() !== 0) begin
         n_bad++;
         $display("FAIL withdrawn_req: %0d grants after withdrawal, need 0", g_id_q.size());
      end
      busy_mode = 2;
      req = 4'b0001;
      repeat (3) @(negedge clk);
      busy_mode = 0;
      c0 = cyc;
      exp = pick(model_last, req);
      expect_grant("ext_busy_grant", exp, req_data[exp*DW +: DW], gc);
      n_cmp++;
      if (gc !== c0 + 1) begin
         n_bad++;
         $display("FAIL ext_busy_latency: valid at cycle %0d, need %0d", gc, c0 + 1);
      end
      req = '0;
      wait_done("ext_busy_done", d0 + 1);
   endtask

   task automatic test_reset_mid();
      int d0, e0, gc, exp;
      req_data = $urandom;
      req = 4'b0010;
      exp = pick(model_last, req);
      expect_grant("mid_grant", exp, req_data[exp*DW +: DW], gc);
      req = '0;
      repeat (4) @(negedge clk);
      d0 = done_cnt; e0 = err_cnt;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({ack, tx_p_data, tx_data_valid, gnt_id, done, err} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset_async: data=%h id=%0d valid=%b, need all zero immediately",
                  tx_p_data, gnt_id, tx_data_valid);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_last = NUM_REQ - 1;
      repeat (FRAME + 4) @(negedge clk);
      n_cmp++;
      if (done_cnt !== d0 || err_cnt !== e0) begin
         n_bad++;
         $display("FAIL mid_reset_silent: dones=%0d errs=%0d after reset, need 0 0", done_cnt - d0, err_cnt - e0);
      end
      req_data = $urandom;
      req = 4'b1001;
      for (int i = 0; i < 2; i++) begin
         exp = pick(model_last, req);
         expect_grant($sformatf("post_reset%0d", i), exp, req_data[exp*DW +: DW], gc);
      end
      req = '0;
      wait_done("post_reset_done", d0 + 2);
   endtask

   task automatic test_random();
      int d0, gc, exp;
      d0 = done_cnt;
      for (int i = 0; i < 30; i++) begin
         req_data = {$urandom};
         req = NUM_REQ'($urandom_range(1, 15));
         exp = pick(model_last, req);
         expect_grant($sformatf("rand%0d", i), exp, req_data[exp*DW +: DW], gc);
         req = '0;
         req_data = {$urandom};
         wait_done($sformatf("rand_done%0d", i), d0 + i + 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_timeout();
      test_ext_busy();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
